// File: rtl/dcache_assoc_ctrl_if.sv
// dcache_assoc_ctrl_if: datapath request and memory-side handshake bundle for the cache controller
interface dcache_assoc_ctrl_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int TAG_W = 26
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);
  logic             halt;
  logic             dmemREN;
  logic             dmemWEN;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tagbits;
  logic             hit;
  logic             miss;
  logic [WAY_W-1:0] hit_way;
  logic             WENcache;
  logic             wb_req;
  logic [TAG_W-1:0] wb_tag;
  logic             fill_req;
  logic [IDX_W-1:0] busy_idx;
  logic [WAY_W-1:0] busy_way;
  logic             mem_done;
  // master: datapath plus memory side driving requests and completions
  modport master (
    output halt, dmemREN, dmemWEN, index, tagbits, mem_done,
    input  hit, miss, hit_way, WENcache, wb_req, wb_tag, fill_req, busy_idx, busy_way
  );
  // slave: the lookup/replacement controller
  modport slave (
    input  halt, dmemREN, dmemWEN, index, tagbits, mem_done,
    output hit, miss, hit_way, WENcache, wb_req, wb_tag, fill_req, busy_idx, busy_way
  );
endinterface

// File: rtl/dcache_assoc_ctrl.sv
// dcache_assoc_ctrl: N-way set-associative tag/valid/dirty/true-LRU controller with writeback->fill miss sequencing
module dcache_assoc_ctrl #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int TAG_W = 26
) (
  input logic               CLK,
  input logic               RST,
  dcache_assoc_ctrl_if.slave bus
);
  localparam int AGE_W = $clog2(WAYS);
  localparam int WAY_W = AGE_W;
  localparam int IDX_W = $clog2(SETS);
  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  state_t           state;
  logic [TAG_W-1:0] tag [SETS][WAYS];
  logic [WAYS-1:0]  valid [SETS];
  logic [WAYS-1:0]  dirty [SETS];
  ages_t            age [SETS];
  logic [TAG_W-1:0] req_tag;
  logic             req, wr, match, inv_any;
  logic [WAY_W-1:0] match_way, inv_way, lru_way, victim;
  logic [IDX_W-1:0] idx;
  // Promote way w to MRU; only ways younger than it age, so ages stay a permutation
  function automatic ages_t touch(input ages_t a, input logic [WAY_W-1:0] w);
    touch = a;
    for (int v = 0; v < WAYS; v++)
      if (a[v] < a[w]) touch[v] = a[v] + 1'b1;
    touch[w] = '0;
  endfunction
  assign idx          = bus.index;
  assign bus.hit      = req & match;
  assign bus.miss     = req & !match;
  assign bus.hit_way  = (req & match) ? match_way : '0;
  assign bus.WENcache = req & match & wr;
  // Lookup: lowest matching way, lowest invalid way and the oldest way of the addressed set
  always_comb begin
    req       = (bus.dmemREN | bus.dmemWEN) & !bus.halt & (state == IDLE);
    wr        = bus.dmemWEN & !bus.dmemREN;
    match     = 1'b0;
    match_way = '0;
    inv_any   = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tag[idx][w] == bus.tagbits) begin
        match     = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!valid[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age[idx][w] == AGE_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim = inv_any ? inv_way : lru_way;
  end
  // Hit bookkeeping and the single outstanding miss sequence IDLE->(WB)->FILL->DONE
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      bus.wb_req   <= 1'b0;
      bus.fill_req <= 1'b0;
      bus.wb_tag   <= '0;
      bus.busy_idx <= '0;
      bus.busy_way <= '0;
      req_tag      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= AGE_W'(w);
      end
    end else begin
      case (state)
        IDLE: begin
          if (req && match) begin
            age[idx] <= touch(age[idx], match_way);
            if (wr) dirty[idx][match_way] <= 1'b1;
          end else if (req) begin
            bus.busy_idx <= idx;
            bus.busy_way <= victim;
            req_tag      <= bus.tagbits;
            if (valid[idx][victim] && dirty[idx][victim]) begin
              state      <= WB;
              bus.wb_req <= 1'b1;
              bus.wb_tag <= tag[idx][victim];
            end else begin
              state        <= FILL;
              bus.fill_req <= 1'b1;
            end
          end
        end
        WB: if (bus.mem_done) begin
          dirty[bus.busy_idx][bus.busy_way] <= 1'b0;
          bus.wb_req   <= 1'b0;
          bus.fill_req <= 1'b1;
          state        <= FILL;
        end
        FILL: if (bus.mem_done) begin
          tag[bus.busy_idx][bus.busy_way]   <= req_tag;
          valid[bus.busy_idx][bus.busy_way] <= 1'b1;
          dirty[bus.busy_idx][bus.busy_way] <= 1'b0;
          age[bus.busy_idx]                 <= touch(age[bus.busy_idx], bus.busy_way);
          bus.fill_req <= 1'b0;
          state        <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// tb_dcache_assoc_ctrl: directed and model-checked random stimulus for dcache_assoc_ctrl
module tb_dcache_assoc_ctrl;
  localparam int WAYS  = 4;
  localparam int SETS  = 8;
  localparam int TAG_W = 26;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [TAG_W-1:0] mtag [SETS][WAYS];
  bit   mval [SETS][WAYS];
  bit   mdirty [SETS][WAYS];
  int   mage [SETS][WAYS];
  int   op, ridx, mw, vic;
  bit   mh, ew;
  logic [TAG_W-1:0] rt;
  dcache_assoc_ctrl_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) bus ();
  dcache_assoc_ctrl #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  always #5 CLK = ~CLK;
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask
  task automatic drive(input logic ren, input logic wen, input logic [2:0] idx, input logic [TAG_W-1:0] t);
    bus.dmemREN = ren;
    bus.dmemWEN = wen;
    bus.index   = idx;
    bus.tagbits = t;
    #1;
  endtask
  task automatic pulse_done();
    bus.mem_done = 1'b1;
    cyc();
    bus.mem_done = 1'b0;
  endtask
  task automatic probe(input string nm, input logic [2:0] idx, input logic [TAG_W-1:0] t, input logic eh, input logic em);
    drive(1'b1, 1'b0, idx, t);
    chk({nm, "_hit"}, bus.hit, eh);
    chk({nm, "_miss"}, bus.miss, em);
    drive(1'b0, 1'b0, idx, t);
  endtask
  task automatic hit_req(input logic ren, input logic wen, input logic [2:0] idx, input logic [TAG_W-1:0] t, input logic [1:0] ew_);
    drive(ren, wen, idx, t);
    chk("hit", bus.hit, 1);
    chk("hit_way", bus.hit_way, ew_);
    chk("WENcache", bus.WENcache, wen & !ren);
    cyc();
    drive(1'b0, 1'b0, idx, t);
  endtask
  task automatic miss_fill(input logic [2:0] idx, input logic [TAG_W-1:0] t, input logic [1:0] ew_, input logic wb, input logic [TAG_W-1:0] wbt);
    drive(1'b1, 1'b0, idx, t);
    chk("miss", bus.miss, 1);
    chk("miss_hit", bus.hit, 0);
    cyc();
    drive(1'b0, 1'b0, idx, t);
    chk("busy_idx", bus.busy_idx, idx);
    chk("busy_way", bus.busy_way, ew_);
    chk("wb_req", bus.wb_req, wb);
    chk("fill_req", bus.fill_req, !wb);
    if (wb) begin
      chk("wb_tag", bus.wb_tag, wbt);
      repeat (2) begin
        cyc();
        chk("wb_hold", bus.wb_req, 1);
      end
      pulse_done();
      chk("wb_drop", bus.wb_req, 0);
      chk("fill_after_wb", bus.fill_req, 1);
    end
    pulse_done();
    chk("fill_drop", bus.fill_req, 0);
    drive(1'b1, 1'b0, idx, t);
    chk("done_hit", bus.hit, 0);
    chk("done_miss", bus.miss, 0);
    cyc();
    drive(1'b0, 1'b0, idx, t);
  endtask
  task automatic mtouch(input int s, input int w);
    int a;
    a = mage[s][w];
    for (int v = 0; v < WAYS; v++) if (mage[s][v] < a) mage[s][v]++;
    mage[s][w] = 0;
  endtask
  initial begin
    bus.halt = 1'b0;
    bus.mem_done = 1'b0;
    drive(1'b0, 1'b0, 3'd0, '0);
    repeat (2) cyc();
    chk("rst_wb_req", bus.wb_req, 0);
    chk("rst_fill_req", bus.fill_req, 0);
    chk("rst_busy_idx", bus.busy_idx, 0);
    chk("rst_busy_way", bus.busy_way, 0);
    chk("rst_wb_tag", bus.wb_tag, 0);
    chk("rst_hit", bus.hit, 0);
    RST = 1'b0;
    miss_fill(3'd3, 26'h10, 2'd0, 1'b0, '0);
    hit_req(1'b1, 1'b0, 3'd3, 26'h10, 2'd0);
    miss_fill(3'd3, 26'h11, 2'd1, 1'b0, '0);
    miss_fill(3'd3, 26'h12, 2'd2, 1'b0, '0);
    miss_fill(3'd3, 26'h13, 2'd3, 1'b0, '0);
    hit_req(1'b1, 1'b0, 3'd3, 26'h10, 2'd0);
    miss_fill(3'd3, 26'h14, 2'd1, 1'b0, '0);
    probe("evicted_b", 3'd3, 26'h11, 1'b0, 1'b1);
    hit_req(1'b1, 1'b0, 3'd3, 26'h14, 2'd1);
    miss_fill(3'd5, 26'h20, 2'd0, 1'b0, '0);
    miss_fill(3'd5, 26'h21, 2'd1, 1'b0, '0);
    miss_fill(3'd5, 26'h22, 2'd2, 1'b0, '0);
    miss_fill(3'd5, 26'h23, 2'd3, 1'b0, '0);
    hit_req(1'b0, 1'b1, 3'd5, 26'h22, 2'd2);
    hit_req(1'b1, 1'b0, 3'd5, 26'h20, 2'd0);
    hit_req(1'b1, 1'b0, 3'd5, 26'h21, 2'd1);
    hit_req(1'b1, 1'b0, 3'd5, 26'h23, 2'd3);
    miss_fill(3'd5, 26'h30, 2'd2, 1'b1, 26'h22);
    probe("old_dirty_tag", 3'd5, 26'h22, 1'b0, 1'b1);
    hit_req(1'b1, 1'b0, 3'd5, 26'h30, 2'd2);
    hit_req(1'b1, 1'b0, 3'd5, 26'h23, 2'd3);
    hit_req(1'b1, 1'b0, 3'd5, 26'h21, 2'd1);
    hit_req(1'b1, 1'b0, 3'd5, 26'h20, 2'd0);
    miss_fill(3'd5, 26'h31, 2'd2, 1'b0, '0);
    hit_req(1'b1, 1'b1, 3'd5, 26'h23, 2'd3);
    bus.halt = 1'b1;
    probe("halt", 3'd5, 26'h21, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'd5, 26'h21);
    cyc();
    drive(1'b1, 1'b0, 3'd5, 26'h99);
    cyc();
    drive(1'b0, 1'b0, 3'd5, 26'h99);
    chk("halt_no_fill", bus.fill_req, 0);
    chk("halt_no_wb", bus.wb_req, 0);
    bus.halt = 1'b0;
    miss_fill(3'd5, 26'h41, 2'd1, 1'b0, '0);
    hit_req(1'b1, 1'b0, 3'd5, 26'h20, 2'd0);
    hit_req(1'b1, 1'b0, 3'd5, 26'h31, 2'd2);
    miss_fill(3'd5, 26'h42, 2'd3, 1'b0, '0);
    miss_fill(3'd0, 26'h50, 2'd0, 1'b0, '0);
    hit_req(1'b1, 1'b0, 3'd0, 26'h50, 2'd0);
    drive(1'b1, 1'b0, 3'd0, 26'h51);
    cyc();
    drive(1'b0, 1'b0, 3'd0, 26'h51);
    chk("pre_rst_fill", bus.fill_req, 1);
    chk("pre_rst_way", bus.busy_way, 1);
    RST = 1'b1;
    cyc();
    chk("rst_mid_fill", bus.fill_req, 0);
    chk("rst_mid_wb", bus.wb_req, 0);
    RST = 1'b0;
    probe("rst_inval0", 3'd0, 26'h50, 1'b0, 1'b1);
    probe("rst_inval5", 3'd5, 26'h42, 1'b0, 1'b1);
    miss_fill(3'd0, 26'h50, 2'd0, 1'b0, '0);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mval[s][w] = 0;
        mdirty[s][w] = 0;
        mage[s][w] = w;
        mtag[s][w] = '0;
      end
    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 2);
      ridx = $urandom_range(1, 2);
      rt   = TAG_W'(26'h60 + $urandom_range(0, 6));
      mh = 0;
      mw = 0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (mval[ridx][w] && mtag[ridx][w] == rt) begin
          mh = 1;
          mw = w;
        end
      drive(op != 1, op != 0, 3'(ridx), rt);
      chk("rnd_hit", bus.hit, mh);
      chk("rnd_miss", bus.miss, !mh);
      chk("rnd_hit_way", bus.hit_way, mh ? mw : 0);
      chk("rnd_WENcache", bus.WENcache, mh && op == 1);
      cyc();
      drive(1'b0, 1'b0, 3'(ridx), rt);
      if (mh) begin
        mtouch(ridx, mw);
        if (op == 1) mdirty[ridx][mw] = 1;
      end else begin
        vic = -1;
        for (int w = 0; w < WAYS; w++) if (!mval[ridx][w] && vic < 0) vic = w;
        if (vic < 0) for (int w = 0; w < WAYS; w++) if (mage[ridx][w] == WAYS - 1) vic = w;
        ew = mval[ridx][vic] && mdirty[ridx][vic];
        chk("rnd_busy_way", bus.busy_way, vic);
        chk("rnd_wb_req", bus.wb_req, ew);
        chk("rnd_fill_req", bus.fill_req, !ew);
        if (ew) begin
          chk("rnd_wb_tag", bus.wb_tag, mtag[ridx][vic]);
          repeat ($urandom_range(0, 2)) cyc();
          pulse_done();
          chk("rnd_fill_after_wb", bus.fill_req, 1);
        end
        repeat ($urandom_range(0, 2)) cyc();
        pulse_done();
        chk("rnd_fill_drop", bus.fill_req, 0);
        cyc();
        mtag[ridx][vic] = rt;
        mval[ridx][vic] = 1;
        mdirty[ridx][vic] = 0;
        mtouch(ridx, vic);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
